mult_16b_seq: RTL



---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_16b_seq_adder.sv | 22 ++
 rtl/mult_16b_seq.sv | 86 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier.
package mult_pkg;
  localparam int WIDTH = 16;
  localparam logic [3:0] ITER_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_16b_seq_adder.sv
// 16-bit ripple-carry adder used as the multiplier's partial-sum datapath.
module mult_16b_seq_adder
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) |
                      (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/mult_16b_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier, 17 cycles per product.
module mult_16b_seq
  import mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_mcand, w_mcand_nxt;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [3:0]           r_count, w_count_nxt;
  logic [2*WIDTH-1:0]   r_product, w_product_nxt;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [2*WIDTH-1:0]   w_shifted;

  assign w_addend = r_acc[0] ? r_mcand : '0;

  mult_16b_seq_adder u_adder (
    .i_a    (r_acc[2*WIDTH-1:WIDTH]),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry-out becomes the new MSB so no partial-sum bit is lost.
  assign w_shifted = {w_cout, w_sum, r_acc[WIDTH-1:1]};

  always_comb begin
    w_state_nxt   = r_state;
    w_mcand_nxt   = r_mcand;
    w_acc_nxt     = r_acc;
    w_count_nxt   = r_count;
    w_product_nxt = r_product;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_mcand_nxt = a;
          w_acc_nxt   = {{WIDTH{1'b0}}, b};
          w_count_nxt = 4'd0;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_acc_nxt   = w_shifted;
        w_count_nxt = r_count + 4'd1;
        if (r_count == ITER_LAST) begin
          w_product_nxt = w_shifted;
          w_state_nxt   = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_count   <= 4'd0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mcand   <= w_mcand_nxt;
      r_acc     <= w_acc_nxt;
      r_count   <= w_count_nxt;
      r_product <= w_product_nxt;
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;
endmodule
